// File: rtl/servo_angle_ramp.sv
// rtl/servo_angle_ramp.sv - slew-rate-limited direction-to-angle servo stage
// Latches a target from pos_dir/neg_dir and walks angle toward it by STEP every tick.
module servo_angle_ramp #(
  parameter int W              = 8,
  parameter int POS_ANGLE      = 110,
  parameter int NEG_ANGLE      = 70,
  parameter int CENTER_ANGLE   = 90,
  parameter int STEP           = 2,
  parameter int STEP_DIV       = 50000,
  parameter int RECENTER_TICKS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pos_dir,
  input  logic         neg_dir,
  output logic [W-1:0] angle,
  output logic [W-1:0] target,
  output logic         moving,
  output logic         at_target
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int IW = (RECENTER_TICKS > 0) ? $clog2(RECENTER_TICKS + 1) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(STEP_DIV - 1);
  localparam logic [IW-1:0] RC_LAST   = IW'(RECENTER_TICKS);
  localparam logic [W:0]    STEP_W    = (W + 1)'(STEP);
  localparam logic [W-1:0]  POS_W     = W'(POS_ANGLE);
  localparam logic [W-1:0]  NEG_W     = W'(NEG_ANGLE);
  localparam logic [W-1:0]  CENTER_W  = W'(CENTER_ANGLE);

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } ramp_state_e;

  ramp_state_e   state;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [W-1:0]  angle_q, angle_d;
  logic [W-1:0]  target_q, target_d;
  logic          moving_q, moving_d;
  logic          at_target_q, at_target_d;
  logic          tick;
  logic          recenter_fire;
  logic [W:0]    diff;
  logic [W:0]    step_amt;

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + CW'(1);

    if (angle_q < target_q) begin
      state = RAMP_UP;
    end else if (angle_q > target_q) begin
      state = RAMP_DOWN;
    end else begin
      state = IDLE;
    end

    // Distance is taken in W+1 bits so the clamp below can never wrap angle.
    diff = '0;
    case (state)
      RAMP_UP:   diff = {1'b0, target_q} - {1'b0, angle_q};
      RAMP_DOWN: diff = {1'b0, angle_q} - {1'b0, target_q};
      default:   diff = '0;
    endcase
    step_amt = (diff < STEP_W) ? diff : STEP_W;

    angle_d = angle_q;
    if (tick) begin
      case (state)
        RAMP_UP:   angle_d = W'({1'b0, angle_q} + step_amt);
        RAMP_DOWN: angle_d = W'({1'b0, angle_q} - step_amt);
        default:   angle_d = angle_q;
      endcase
    end

    recenter_fire = 1'b0;
    idle_cnt_d    = '0;
    if (RECENTER_TICKS > 0) begin
      if (pos_dir || neg_dir || (target_q == CENTER_W)) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == RC_LAST) begin
        recenter_fire = 1'b1;
        idle_cnt_d    = '0;
      end else if (tick) begin
        idle_cnt_d = idle_cnt_q + IW'(1);
      end else begin
        idle_cnt_d = idle_cnt_q;
      end
    end

    target_d = target_q;
    if (pos_dir && !neg_dir) begin
      target_d = POS_W;
    end else if (neg_dir && !pos_dir) begin
      target_d = NEG_W;
    end else if (pos_dir && neg_dir) begin
      target_d = CENTER_W;
    end else if (recenter_fire) begin
      target_d = CENTER_W;
    end

    // Status lags the registered angle/target by one edge.
    moving_d    = (angle_q != target_q);
    at_target_d = !moving_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      angle_q     <= CENTER_W;
      target_q    <= CENTER_W;
      moving_q    <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      angle_q     <= angle_d;
      target_q    <= target_d;
      moving_q    <= moving_d;
      at_target_q <= at_target_d;
    end
  end

  assign angle     = angle_q;
  assign target    = target_q;
  assign moving    = moving_q;
  assign at_target = at_target_q;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// tb/tb_servo_angle_ramp.sv - vector table plus angle scoreboard for servo_angle_ramp
module tb_servo_angle_ramp;

  localparam int W    = 8;
  localparam int POS  = 110;
  localparam int NEG  = 70;
  localparam int CTR  = 90;
  localparam int STEP = 3;
  localparam int DIV  = 4;
  localparam int RCT  = 5;
  localparam int NVEC = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pos_dir = 1'b0;
  logic         neg_dir = 1'b0;
  logic [W-1:0] angle, target, nr_angle, nr_target;
  logic         moving, at_target, nr_moving, nr_at_target;

  servo_angle_ramp #(
    .W(W), .POS_ANGLE(POS), .NEG_ANGLE(NEG), .CENTER_ANGLE(CTR),
    .STEP(STEP), .STEP_DIV(DIV), .RECENTER_TICKS(RCT)
  ) dut (
    .clk(clk), .rst(rst), .pos_dir(pos_dir), .neg_dir(neg_dir),
    .angle(angle), .target(target), .moving(moving), .at_target(at_target)
  );

  servo_angle_ramp #(
    .W(W), .POS_ANGLE(POS), .NEG_ANGLE(NEG), .CENTER_ANGLE(CTR),
    .STEP(STEP), .STEP_DIV(DIV), .RECENTER_TICKS(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .pos_dir(pos_dir), .neg_dir(neg_dir),
    .angle(nr_angle), .target(nr_target), .moving(nr_moving), .at_target(nr_at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         pos;
    logic         neg;
    logic [W-1:0] ang;
    logic [W-1:0] tgt;
    logic         mov;
    logic         at;
  } vec_t;

  typedef struct {
    logic [W-1:0] ang;
    bit           gap;
  } sb_t;

  vec_t         vecs[NVEC];
  sb_t          sb_q[$];
  sb_t          mon_e;
  bit           mon_en = 1'b0;
  logic [W-1:0] prev_ang;
  int           cyc = 0;
  int           last_chg = 0;
  int           tests = 0;
  int           fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic p, input logic n,
                              input int a, input int t, input logic m, input logic at);
    vec_t v;
    v.rst = r; v.pos = p; v.neg = n;
    v.ang = a[W-1:0]; v.tgt = t[W-1:0];
    v.mov = m; v.at = at;
    return v;
  endfunction

  task automatic push(input int v, input bit g);
    sb_t e;
    e.ang = v[W-1:0];
    e.gap = g;
    sb_q.push_back(e);
  endtask

  // Expected angle sequence from 'from' to 'to' in STEP-sized, clamped moves.
  task automatic push_ramp(input int from, input int to, input bit first_gap);
    int a;
    bit g;
    a = from;
    g = first_gap;
    while (a != to) begin
      if (to > a) a = (to - a > STEP) ? a + STEP : to;
      else        a = (a - to > STEP) ? a - STEP : to;
      push(a, g);
      g = 1'b1;
    end
  endtask

  task automatic wait_angle(input string name, input int v, input int budget);
    repeat (budget) begin
      @(negedge clk);
      if (int'(angle) == v) break;
    end
    check(name, 32'(angle), v);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (angle !== prev_ang) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: angle changed to %0d, expected no change", angle);
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_angle", 32'(angle), 32'(mon_e.ang));
          if (mon_e.gap) check("sb_gap", cyc - last_chg, DIV);
        end
        last_chg = cyc;
        prev_ang = angle;
      end
      check("complement", 32'(moving), 32'(!at_target));
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = mk(1, 0, 0, CTR, CTR, 0, 1);
    vecs[1]  = mk(1, 0, 0, CTR, CTR, 0, 1);
    vecs[2]  = mk(1, 0, 0, CTR, CTR, 0, 1);
    vecs[3]  = mk(0, 0, 0, CTR, CTR, 0, 1);
    vecs[4]  = mk(0, 0, 0, CTR, CTR, 0, 1);
    vecs[5]  = mk(0, 0, 0, CTR, CTR, 0, 1);
    vecs[6]  = mk(0, 0, 0, CTR, CTR, 0, 1);
    vecs[7]  = mk(0, 1, 0, CTR, POS, 0, 1);
    vecs[8]  = mk(0, 0, 0, CTR, POS, 1, 0);
    vecs[9]  = mk(0, 0, 0, CTR, POS, 1, 0);
    vecs[10] = mk(0, 0, 0, 93,  POS, 1, 0);
    vecs[11] = mk(0, 0, 0, 93,  POS, 1, 0);
    vecs[12] = mk(0, 0, 0, 93,  POS, 1, 0);
    vecs[13] = mk(0, 0, 0, 93,  POS, 1, 0);
    vecs[14] = mk(0, 0, 0, 96,  POS, 1, 0);

    // Reset, idle stability, one-cycle pos pulse latency and first two steps.
    for (int i = 0; i < NVEC; i++) begin
      rst     = vecs[i].rst;
      pos_dir = vecs[i].pos;
      neg_dir = vecs[i].neg;
      if (vecs[i].pos) push_ramp(CTR, POS, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_angle", i), 32'(angle), 32'(vecs[i].ang));
      check($sformatf("vec%0d_target", i), 32'(target), 32'(vecs[i].tgt));
      check($sformatf("vec%0d_moving", i), 32'(moving), 32'(vecs[i].mov));
      check($sformatf("vec%0d_at_target", i), 32'(at_target), 32'(vecs[i].at));
      if (i == 0) begin
        prev_ang = CTR[W-1:0];
        mon_en   = 1'b1;
      end
    end

    // Finish the up-ramp with pos held so recenter cannot interfere.
    pos_dir = 1'b1;
    wait_angle("A_reach_pos", POS, 100);
    check("A_target", 32'(target), POS);
    @(negedge clk);
    check("A_at_target", 32'(at_target), 1);
    check("A_moving", 32'(moving), 0);
    repeat (8) @(negedge clk);
    check("A_hold", 32'(angle), POS);

    // Both asserted from 110 -> center.
    neg_dir = 1'b1;
    push_ramp(POS, CTR, 1'b0);
    @(negedge clk);
    check("C_target", 32'(target), CTR);
    wait_angle("C_reach_ctr", CTR, 100);
    @(negedge clk);
    check("C_at_target", 32'(at_target), 1);
    pos_dir = 1'b0;
    neg_dir = 1'b0;

    // Reversal at 99 during an up-ramp.
    repeat (3) @(negedge clk);
    pos_dir = 1'b1;
    push_ramp(CTR, 99, 1'b0);
    @(negedge clk);
    pos_dir = 1'b0;
    wait_angle("B_reach_99", 99, 100);
    neg_dir = 1'b1;
    push_ramp(99, NEG, 1'b1);
    @(negedge clk);
    check("B_target", 32'(target), NEG);
    wait_angle("B_reach_neg", NEG, 200);
    neg_dir = 1'b0;

    // Recenter after RCT idle ticks; the RECENTER_TICKS=0 instance must stay put.
    push_ramp(NEG, CTR, 1'b0);
    n = 0;
    while (target != CTR[W-1:0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("E_recenter_delay", n, 21);
    wait_angle("E_reach_ctr", CTR, 100);
    check("E_nr_angle", 32'(nr_angle), NEG);
    check("E_nr_target", 32'(nr_target), NEG);
    check("E_nr_at_target", 32'(nr_at_target), 1);

    // Reset mid-ramp at 99, then tick phase restarts from release.
    repeat (3) @(negedge clk);
    pos_dir = 1'b1;
    push_ramp(CTR, 99, 1'b0);
    @(negedge clk);
    pos_dir = 1'b0;
    wait_angle("F_reach_99", 99, 100);
    rst = 1'b1;
    push(CTR, 1'b0);
    @(negedge clk);
    check("F_rst_angle", 32'(angle), CTR);
    check("F_rst_target", 32'(target), CTR);
    check("F_rst_moving", 32'(moving), 0);
    check("F_rst_at_target", 32'(at_target), 1);
    rst     = 1'b0;
    pos_dir = 1'b1;
    push(93, 1'b0);
    @(negedge clk);
    pos_dir = 1'b0;
    check("F_target", 32'(target), POS);
    repeat (2) begin
      @(negedge clk);
      check("F_no_early_tick", 32'(angle), CTR);
    end
    @(negedge clk);
    check("F_first_tick", 32'(angle), 93);
    @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/servo_angle_ramp.md
# servo_angle_ramp

Slew-rate-limited successor to the direction-to-angle servo stage. Converts the `pos_dir`/`neg_dir` steering requests into a registered target angle, then walks the output `angle` toward that target in fixed steps at a programmable tick rate, so the servo never sees a full-swing jump. It adds parametrised width and angles, a defined both-asserted case, an optional auto-recenter timeout, and status outputs. It sits between the direction decoder and the servo PWM generator, which consumes `angle` unchanged.

## Interface
- `W`, 8: angle width in bits.
- `POS_ANGLE`, 110: target angle when `pos_dir` is asserted alone.
- `NEG_ANGLE`, 70: target angle when `neg_dir` is asserted alone.
- `CENTER_ANGLE`, 90: reset, recenter and both-asserted target. Legal only when NEG_ANGLE <= CENTER_ANGLE <= POS_ANGLE <= 2^W-1.
- `STEP`, 2: maximum angle change per tick, 1..2^W-1.
- `STEP_DIV`, 50000: clock cycles per tick, >= 1.
- `RECENTER_TICKS`, 0: idle ticks before auto-return to center; 0 disables the feature.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pos_dir`  in  1  positive-direction request, level-sampled every cycle.
- `neg_dir`  in  1  negative-direction request, level-sampled every cycle.
- `angle`  out  W  current commanded angle, registered.
- `target`  out  W  current target angle, registered.
- `moving`  out  1  high while `angle` != `target`.
- `at_target`  out  1  high while `angle` == `target`.

## Operation
- Reset (`rst`=1 at a clock edge) forces `angle`=CENTER_ANGLE, `target`=CENTER_ANGLE, tick counter=0, idle counter=0, `moving`=0, `at_target`=1. Reset takes priority over all other activity, including a ramp in progress.
- Target select, evaluated every cycle:
  - `pos_dir` & !`neg_dir`: target becomes POS_ANGLE.
  - `neg_dir` & !`pos_dir`: target becomes NEG_ANGLE.
  - Both asserted: target becomes CENTER_ANGLE. This replaces the older pos-priority rule.
  - Neither asserted: target holds, subject to the recenter rule below.
- Tick generator:
  - Counter runs freely from 0 to STEP_DIV-1, then wraps to 0.
  - `tick` is asserted during the cycle in which the counter equals STEP_DIV-1.
  - With STEP_DIV=1, `tick` is asserted every cycle.
- Ramp state machine:
  - States: IDLE (`angle`==`target`), RAMP_UP (`angle`<`target`), RAMP_DOWN (`angle`>`target`).
  - The state is derived from the registered `angle` and `target` each cycle.
  - On a tick in RAMP_UP: `angle` += min(STEP, `target`-`angle`).
  - On a tick in RAMP_DOWN: `angle` -= min(STEP, `angle`-`target`).
  - On a tick in IDLE: no change.
  - `angle` never overshoots `target` and never wraps. Compute the difference unsigned in W+1 bits before the min comparison.
- Reversal mid-ramp: the step on the next tick uses the new target's direction. No residual step is taken in the old direction.
- Recenter (active only when RECENTER_TICKS>0):
  - The idle counter increments on each tick while neither dir input is asserted and `target` != CENTER_ANGLE.
  - The idle counter clears in any cycle where either dir input is asserted, or where `target`==CENTER_ANGLE.
  - When the count reaches RECENTER_TICKS, `target` becomes CENTER_ANGLE on the next edge and the counter clears.
- `moving` and `at_target` are registered, and each is the complement of the other at all times.

## Timing
- Target latency: a dir input sampled at edge N appears on `target` after edge N; `moving` updates on the following edge.
- First angle step: on the first tick edge at or after the edge where `target` changed. Worst-case delay is STEP_DIV cycles.
- Full-swing duration from a to b: ceil(|b-a|/STEP) ticks.
- A dir pulse of one cycle is sufficient; `target` latches it.
- Recenter fires RECENTER_TICKS ticks after the last cycle in which a dir input was asserted, provided `target` != CENTER_ANGLE.
- Reset mid-ramp: outputs hold their reset values from the edge after `rst` is sampled high. The ramp does not resume after `rst` deasserts.

## Test plan
Bench parameters: W=8, POS=110, NEG=70, CENTER=90, STEP=3, STEP_DIV=4, RECENTER_TICKS=5.
- Reset: hold `rst` for 3 cycles, then release -> `angle`=90, `target`=90, `at_target`=1, `moving`=0, and all remain stable with no dir input.
- Positive ramp: 1-cycle `pos_dir` pulse -> `target`=110 one edge later; `angle` sequence 93, 96, 99, 102, 105, 108, 110 with one value per 4 cycles; `at_target`=1 after 110; no value above 110.
- Reversal: raise `neg_dir` when `angle`=99 during the up-ramp -> `target`=70; next ticks give 96, 93, ... 72, 70; never 102.
- Both asserted: from `angle`=110, hold both inputs high -> `target`=90; `angle` goes 107, 104, ... 92, 90.
- Recenter: reach `angle`=70 with no dir input -> 5 ticks later `target`=90, and `angle` ramps 73 ... 90; with RECENTER_TICKS=0 the output stays at 70 indefinitely.
- Reset mid-ramp: assert `rst` at `angle`=99 -> `angle`=90, `target`=90, `moving`=0 after that edge; the tick counter restarts, so the first tick comes 4 cycles after release.
